// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath multiply unit.
//   - MULT_WIDTH : default operand width of the Booth multiplier
//   - state_t    : multiplier control states (IDLE / RUN / DONE)
//   - booth_op_t : radix-2 Booth recoding of the multiplier bit pair
//   - booth_decode() maps the low bit pair of the partial product to an op
package alu_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Pair is {current multiplier bit, previously shifted-out bit}.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   p_i [2*WIDTH+1:0] current partial product {acc(WIDTH+1), multiplier(WIDTH), q-1}
//   m_i [WIDTH:0]     sign-extended multiplicand
//   p_o [2*WIDTH+1:0] partial product after add/sub and arithmetic shift right by 1
module booth_step
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic signed [2*WIDTH+1:0] p_i,
  input  logic signed [WIDTH:0]     m_i,
  output logic signed [2*WIDTH+1:0] p_o
);

  logic signed [WIDTH:0] acc;
  logic signed [WIDTH:0] sum;

  // The accumulator is one bit wider than the operands so the most negative
  // multiplicand can be subtracted without losing the sign; wrap is intended.
  always_comb begin
    acc = p_i[2*WIDTH+1:WIDTH+1];
    case (booth_decode(p_i[1:0]))
      BOOTH_ADD: sum = acc + m_i;
      BOOTH_SUB: sum = acc - m_i;
      default:   sum = acc;
    endcase
  end

  assign p_o = {sum[WIDTH], sum, p_i[WIDTH:1]};

endmodule

// File: rtl/mult_booth.sv
// Multi-cycle signed WIDTH x WIDTH radix-2 Booth multiplier.
// A start accepted in IDLE or DONE loads the operands; WIDTH iterations later
// the 2*WIDTH-bit product lands in Hi/Lo together with a one-cycle multDone.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   multStart start request (ignored while RUN)
//   A, B      two's complement multiplicand / multiplier, sampled on accept
//   busy      high while iterations are in progress
//   multDone  one-cycle pulse when Hi/Lo receive a new result
//   Hi, Lo    upper / lower half of the signed product, held until next result
module mult_booth
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             multDone,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [2*WIDTH+1:0] p_q, p_d, p_step;
  logic signed [WIDTH:0]    m_q, m_d;
  logic [WIDTH-1:0]         hi_q, hi_d;
  logic [WIDTH-1:0]         lo_q, lo_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic accept;
  logic last_iter;

  assign accept    = multStart && (state_q != ST_RUN);
  assign last_iter = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_i (p_q),
    .m_i (m_q),
    .p_o (p_step)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (multStart) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = multStart ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    p_d    = p_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (accept) begin
      m_d    = {A[WIDTH-1], A};
      p_d    = {{(WIDTH+1){1'b0}}, B, 1'b0};
      cnt_d  = CNT_W'(WIDTH);
      busy_d = 1'b1;
    end else if (state_q == ST_RUN) begin
      p_d   = p_step;
      cnt_d = cnt_q - CNT_W'(1);
      // The result is taken straight from the final step so it appears on
      // the same edge as the last iteration.
      if (last_iter) begin
        hi_d   = p_step[2*WIDTH:WIDTH+1];
        lo_d   = p_step[WIDTH:1];
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign multDone = done_q;
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Directed and pseudo-random checks of the Booth multiplier: latency, busy
// window, multDone pulse width, held results, mid-run restart, back-to-back
// start and asynchronous reset.
module tb_mult_booth;

  logic        clk;
  logic        reset;
  logic        multStart;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        multDone;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_checks;
  int n_errors;

  mult_booth #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .multStart (multStart),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .multDone  (multDone),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands in the low clock phase; returns #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a;
    B = b;
    multStart = 1'b1;
    @(posedge clk);
    #1;
    multStart = 1'b0;
    A = 32'hDEAD_BEEF;
    B = 32'hCAFE_F00D;
  endtask

  // Called #1 after the accepting edge. lat = edges until multDone (-1 on timeout).
  task automatic wait_done(input int restart_at, input logic [31:0] hold_hi,
                           input logic [31:0] hold_lo, output int lat,
                           output int busy_cnt, output bit hold_ok,
                           output bit early_done);
    lat        = -1;
    busy_cnt   = 0;
    hold_ok    = 1'b1;
    early_done = multDone;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cnt++;
      if (Hi !== hold_hi || Lo !== hold_lo) hold_ok = 1'b0;
      if (i == restart_at) begin
        multStart = 1'b1;
        A = 32'h0000_1234;
        B = 32'h0000_0005;
      end else begin
        multStart = 1'b0;
      end
      @(posedge clk);
      #1;
      if (multDone) begin
        lat = i;
        break;
      end
    end
    multStart = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int restart_at, output int busy_cnt);
    logic [31:0] h0, l0;
    int lat;
    bit hold_ok, early;
    h0 = Hi;
    l0 = Lo;
    start_op(a, b);
    wait_done(restart_at, h0, l0, lat, busy_cnt, hold_ok, early);
    check({tag, "_lat"}, 64'(lat), 64'd32);
    check({tag, "_hi"}, {32'd0, Hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, Lo}, {32'd0, exp_lo});
    check({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
    check({tag, "_nodone_at_start"}, {63'd0, early}, 64'd0);
  endtask

  initial begin
    int bc;
    int nd;
    logic [31:0] ra, rb;
    logic signed [63:0] prod;

    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    multStart = 1'b0;
    A         = '0;
    B         = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, Hi}, 64'd0);
    check("rst_lo", {32'd0, Lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, multDone}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 3 * 5
    run_check("t1", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 0, bc);
    check("t1_busy_cycles", 64'(bc), 64'd32);
    check("t1_busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("t1_done_width", {63'd0, multDone}, 64'd0);
    check("t1_idle_busy", {63'd0, busy}, 64'd0);
    check("t1_hold_hi", {32'd0, Hi}, 64'd0);
    check("t1_hold_lo", {32'd0, Lo}, 64'h0000_000F);

    // -7 * 6 = -42
    run_check("t2", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, bc);
    // (-2^31)^2 = 2^62
    run_check("t3", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, bc);
    // -1 * -1
    run_check("t4a", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, bc);
    // -2^31 * 1
    run_check("t4b", 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0, bc);

    // Reset in the middle of an operation
    start_op(32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_hi", {32'd0, Hi}, 64'd0);
    check("t5_rst_lo", {32'd0, Lo}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    check("t5_rst_done", {63'd0, multDone}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (multDone || busy) nd++;
    end
    check("t5_no_done_after_rst", 64'(nd), 64'd0);
    run_check("t5_fresh", 32'd2, 32'd2, 32'h0000_0000, 32'h0000_0004, 0, bc);

    // Start re-asserted mid-run must be ignored
    run_check("t6_restart", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 10, bc);
    // Back-to-back start in the DONE cycle: -1 * 2
    run_check("t6_b2b", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, bc);

    // Pseudo-random signed pairs, back-to-back
    for (int k = 0; k < 250; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k == 0) ra = 32'h8000_0000;
      if (k == 1) rb = 32'h7FFF_FFFF;
      prod = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      run_check("rnd", ra, rb, prod[63:32], prod[31:0], 0, bc);
    end
    @(posedge clk);
    #1;
    check("rnd_done_width", {63'd0, multDone}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
